// File: rtl/lfsr_rand_sched.sv
// lfsr_rand_sched: round-robin scheduler sharing one Galois LFSR among NREQ requesters, with reseed support.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         per-requester request level / one-hot 1-cycle acceptance
//   rsp_valid/rsp_ready/rsp_id/rsp_data  response channel carrying the random word
//   seed_wr / seed_data / seed_ack  reseed request, new seed, 1-cycle capture pulse
//   busy                          high whenever not IDLE
//   lfsr_load/lfsr_shift_en/lfsr_in/lfsr_din/lfsr_out  control and data of the external LFSR
module lfsr_rand_sched #(
    parameter int                WIDTH  = 16,
    parameter int                NREQ   = 4,
    parameter int                SHIFTS = 16,
    parameter logic [WIDTH-1:0]  SEED   = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic                     seed_wr,
    input  logic [WIDTH-1:0]         seed_data,
    output logic                     seed_ack,
    output logic                     busy,
    output logic                     lfsr_load,
    output logic                     lfsr_shift_en,
    output logic [WIDTH-1:0]         lfsr_in,
    output logic                     lfsr_din,
    input  logic [WIDTH-1:0]         lfsr_out
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {INIT, IDLE, LOAD, SHIFT, RESP} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [IW-1:0]    id_q, id_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [IW-1:0]    gnt;
    logic [IW-1:0]    k;

    assign lfsr_din = 1'b0;

    // Scan downwards so the last hit, i.e. the nearest set bit at or after rr_q, wins.
    always_comb begin
        gnt = '0;
        k   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = IW'((int'(rr_q) + i) % NREQ);
            if (req_valid[k]) gnt = k;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        seed_d        = seed_q;
        req_ready     = '0;
        rsp_valid     = 1'b0;
        rsp_id        = '0;
        rsp_data      = '0;
        seed_ack      = 1'b0;
        busy          = 1'b1;
        lfsr_load     = 1'b0;
        lfsr_shift_en = 1'b0;
        lfsr_in       = '0;
        case (state_q)
            INIT: begin
                lfsr_load = 1'b1;
                lfsr_in   = SEED;
                state_d   = IDLE;
            end
            IDLE: begin
                busy = 1'b0;
                if (seed_wr) begin
                    seed_ack = 1'b1;
                    seed_d   = (seed_data == '0) ? SEED : seed_data;
                    state_d  = LOAD;
                end else if (|req_valid) begin
                    req_ready = NREQ'(1) << gnt;
                    id_d      = gnt;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            LOAD: begin
                lfsr_load = 1'b1;
                lfsr_in   = seed_q;
                state_d   = IDLE;
            end
            SHIFT: begin
                lfsr_shift_en = 1'b1;
                cnt_d         = cnt_q + 8'd1;
                state_d       = (cnt_q == 8'(SHIFTS - 1)) ? RESP : SHIFT;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_data  = lfsr_out;
                if (rsp_ready) begin
                    rr_d    = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
        // Quiet outputs while reset is asserted, regardless of the current state.
        if (rst) begin
            req_ready     = '0;
            rsp_valid     = 1'b0;
            rsp_id        = '0;
            rsp_data      = '0;
            seed_ack      = 1'b0;
            busy          = 1'b1;
            lfsr_load     = 1'b0;
            lfsr_shift_en = 1'b0;
            lfsr_in       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            rr_q    <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            seed_q  <= SEED;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
        end
    end
endmodule

// File: tb/tb_lfsr_rand_sched.sv
// tb_lfsr_rand_sched: randomized transaction-level check of lfsr_rand_sched against a reference model.
module tb_lfsr_rand_sched;
    localparam int          W    = 16;
    localparam int          N    = 4;
    localparam int          S    = 16;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] POLY = 16'h6801;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        seed_wr;
    logic [15:0] seed_data;
    logic        seed_ack;
    logic        busy;
    logic        lfsr_load;
    logic        lfsr_shift_en;
    logic [15:0] lfsr_in;
    logic        lfsr_din;
    logic [15:0] lfsr_out;
    logic [15:0] lfsr_q = '0;

    int          total;
    int          bad;
    logic [15:0] m_lfsr;
    int          rr;

    lfsr_rand_sched #(.WIDTH(W), .NREQ(N), .SHIFTS(S), .SEED(SEED)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .seed_wr(seed_wr), .seed_data(seed_data), .seed_ack(seed_ack),
        .busy(busy),
        .lfsr_load(lfsr_load), .lfsr_shift_en(lfsr_shift_en), .lfsr_in(lfsr_in),
        .lfsr_din(lfsr_din), .lfsr_out(lfsr_out)
    );

    // External MSB-shifting Galois LFSR, with no reset of its own.
    assign lfsr_out = lfsr_q;
    always @(posedge clk) begin
        if (lfsr_load) lfsr_q <= lfsr_in;
        else if (lfsr_shift_en) lfsr_q <= {lfsr_q[14:0], lfsr_din} ^ (lfsr_q[15] ? POLY : 16'h0000);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] adv(input logic [15:0] v, input int n);
        int x;
        x = int'(v);
        for (int i = 0; i < n; i++) x = ((x * 2) % 65536) ^ ((x >= 32768) ? int'(POLY) : 0);
        return 16'(x);
    endfunction

    function automatic int pick(input logic [3:0] m, input int p);
        for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (busy,load,shift,in,rv,id,data,ready,ack,din)", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic b, input logic ld, input logic sh, input logic [15:0] li,
                       input logic rv, input logic [1:0] id, input logic [15:0] d, input logic [3:0] rdy,
                       input logic ack);
        @(negedge clk);
        check(tag, 64'({busy, lfsr_load, lfsr_shift_en, lfsr_in, rsp_valid, rsp_id, rsp_data, req_ready, seed_ack, lfsr_din}),
                   64'({b, ld, sh, li, rv, id, d, rdy, ack, 1'b0}));
        @(posedge clk);
        #1;
    endtask

    task automatic reseed(input logic [15:0] s, input logic [3:0] pend);
        logic [15:0] e;
        e = (s == 16'h0) ? SEED : s;
        seed_wr   = 1'b1;
        seed_data = s;
        req_valid = pend;
        cyc("seed_ack", 0, 0, 0, 16'h0, 0, 2'd0, 16'h0, 4'h0, 1);
        seed_wr   = 1'b0;
        seed_data = ~s;
        cyc("seed_load", 1, 1, 0, e, 0, 2'd0, 16'h0, 4'h0, 0);
        m_lfsr    = e;
        req_valid = 4'h0;
    endtask

    task automatic serve(input logic [3:0] mask, input int bp, input bit seed_mid, input bit rst_mid);
        bit          again;
        bit          do_rst;
        int          g;
        logic [15:0] s;
        logic [15:0] e;
        do_rst = rst_mid;
        again  = 1'b1;
        s      = 16'h0;
        g      = 0;
        while (again) begin
            again     = 1'b0;
            req_valid = mask;
            g         = pick(mask, rr);
            cyc("grant", 0, 0, 0, 16'h0, 0, 2'd0, 16'h0, 4'(1) << g, 0);
            req_valid = 4'($urandom);
            for (int i = 0; i < S; i++) begin
                if (do_rst && i == 5) begin
                    rst = 1'b1;
                    cyc("rst_mid", 1, 0, 0, 16'h0, 0, 2'd0, 16'h0, 4'h0, 0);
                    rst       = 1'b0;
                    req_valid = mask;
                    cyc("reinit", 1, 1, 0, SEED, 0, 2'd0, 16'h0, 4'h0, 0);
                    m_lfsr = SEED;
                    rr     = 0;
                    do_rst = 1'b0;
                    again  = 1'b1;
                    break;
                end
                if (seed_mid && i == 7) begin
                    s         = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                    seed_wr   = 1'b1;
                    seed_data = s;
                end
                cyc("shift", 1, 0, 1, 16'h0, 0, 2'd0, 16'h0, 4'h0, 0);
            end
        end
        m_lfsr    = adv(m_lfsr, S);
        rsp_ready = 1'b0;
        for (int i = 0; i < bp; i++) cyc("hold", 1, 0, 0, 16'h0, 1, 2'(g), m_lfsr, 4'h0, 0);
        rsp_ready = 1'b1;
        cyc("resp", 1, 0, 0, 16'h0, 1, 2'(g), m_lfsr, 4'h0, 0);
        rsp_ready = 1'b0;
        rr        = (g + 1) % N;
        if (seed_mid) begin
            e         = (s == 16'h0) ? SEED : s;
            req_valid = 4'($urandom_range(1, 15));
            cyc("ack_first", 0, 0, 0, 16'h0, 0, 2'd0, 16'h0, 4'h0, 1);
            seed_wr   = 1'b0;
            seed_data = 16'($urandom);
            cyc("mid_load", 1, 1, 0, e, 0, 2'd0, 16'h0, 4'h0, 0);
            m_lfsr = e;
        end
        req_valid = 4'h0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req_valid = 4'h0;
        rsp_ready = 1'b0;
        seed_wr   = 1'b0;
        seed_data = 16'h0;
        m_lfsr    = SEED;
        rr        = 0;
        req_valid = 4'hF;
        cyc("rst0", 1, 0, 0, 16'h0, 0, 2'd0, 16'h0, 4'h0, 0);
        cyc("rst1", 1, 0, 0, 16'h0, 0, 2'd0, 16'h0, 4'h0, 0);
        rst       = 1'b0;
        cyc("init", 1, 1, 0, SEED, 0, 2'd0, 16'h0, 4'h0, 0);
        req_valid = 4'h0;
        cyc("idle", 0, 0, 0, 16'h0, 0, 2'd0, 16'h0, 4'h0, 0);
        serve(4'b0001, 0, 0, 0);
        reseed(16'h0001, 4'b0100);
        serve(4'b0100, 0, 0, 0);
        reseed(16'h0000, 4'b0000);
        for (int i = 0; i < 5; i++) serve(4'b1111, (i == 2) ? 10 : 0, 0, 0);
        serve(4'b0010, 1, 1, 0);
        serve(4'b1010, 0, 0, 1);
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) cyc("gap", 0, 0, 0, 16'h0, 0, 2'd0, 16'h0, 4'h0, 0);
            if ($urandom_range(0, 9) < 2)
                reseed(($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom), 4'($urandom));
            else
                serve(4'($urandom_range(1, 15)), $urandom_range(0, 3),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lfsr_rand_sched.md
Name: lfsr_rand_sched

Overview:
- Schedules one shared Galois LFSR instance (MSB- or LSB-shifting, load/shift_en/lfsr_in/din/lfsr_out interface) among NREQ requesters.
- Uses round-robin arbitration.
- Each granted request is served by clocking the LFSR SHIFTS times and returning the resulting state as a random word over a valid/ready response channel.
- Also handles reseeding. It sits between the random-number consumers and the LFSR datapath, and is the only driver of the LFSR control inputs.

Parameters:
- WIDTH, 16: LFSR width; must match the LFSR instance.
- NREQ, 4: number of requesters, 2..16.
- SHIFTS, 16: LFSR shifts per generated word, 1..255.
- SEED, 16'hACE1: seed loaded after reset, and the substitute when a zero seed is written.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request, level, held until accepted.
- req_ready  out  NREQ  one-hot acceptance pulse, 1 cycle.
- rsp_valid  out  1  response word valid.
- rsp_ready  in  1  response consumed.
- rsp_id  out  $clog2(NREQ)  index of the requester being served.
- rsp_data  out  WIDTH  random word.
- seed_wr  in  1  reseed request, level, held until seed_ack.
- seed_data  in  WIDTH  new seed, sampled in the seed_ack cycle.
- seed_ack  out  1  1-cycle pulse when the seed is captured.
- busy  out  1  high in any state other than IDLE.
- lfsr_load  out  1  to LFSR load.
- lfsr_shift_en  out  1  to LFSR shift_en.
- lfsr_in  out  WIDTH  to LFSR lfsr_in.
- lfsr_din  out  1  to LFSR din; constant 0.
- lfsr_out  in  WIDTH  from LFSR lfsr_out.

Behaviour:
- Interface decision (already decided): one clock; reset is synchronous and active-high.
- Reset is sampled on the clk rising edge. It forces state=INIT, rr_ptr=0, cnt=0, seed_reg=SEED.
- All outputs are 0 during reset, including lfsr_load, lfsr_shift_en, lfsr_in, rsp_*, req_ready, seed_ack. busy is 1 during reset.
- Reset mid-operation abandons any in-flight request without a response. The requester keeps req_valid high and is re-arbitrated.
- The LFSR's own reset is independent. INIT guarantees a known LFSR state after every controller reset.
- States:
  - INIT: lfsr_load=1, lfsr_in=SEED, for 1 cycle -> IDLE.
  - IDLE: busy=0. Priority is seed_wr over requests.
    - If seed_wr: seed_ack=1 and capture seed_reg = (seed_data==0) ? SEED : seed_data -> LOAD.
    - Else if any req_valid: grant the first set bit at or after rr_ptr, wrapping modulo NREQ. Pulse req_ready[g]=1, latch id=g, cnt=0 -> SHIFT.
    - Else stay.
  - LOAD: lfsr_load=1, lfsr_in=seed_reg, for 1 cycle -> IDLE.
  - SHIFT: lfsr_shift_en=1 every cycle, cnt++. When cnt==SHIFTS-1 -> RESP. Exactly SHIFTS shift cycles occur.
  - RESP: rsp_valid=1, rsp_id=id, rsp_data=lfsr_out. The LFSR is idle, so rsp_data is stable while rsp_valid is held.
    - On rsp_valid&&rsp_ready: rr_ptr=(id+1) mod NREQ -> IDLE.
    - Otherwise hold: rsp_valid stays high, and id/data are unchanged until accepted.
- Outside their states: lfsr_load=lfsr_shift_en=0, lfsr_in=0, rsp_data=0, rsp_id=0.
- Mutual exclusion: lfsr_load and lfsr_shift_en are never high in the same cycle.
- Latency: request accepted in cycle T (req_ready high). rsp_valid first rises at T+SHIFTS+1. Minimum request-to-request spacing is SHIFTS+2 cycles with rsp_ready tied high.
- Reseed latency: seed_ack in cycle T, lfsr_load in T+1, IDLE in T+2.
- seed_wr arriving while not IDLE waits. It is serviced at the next IDLE cycle, ahead of any pending req_valid.
- A requester dropping req_valid before acceptance is legal and simply not granted. req_valid is ignored outside IDLE.
- Round-robin pointer advances only on response completion, never on reseed. Starvation bound: NREQ-1 other services.

Test Plan:
1. Reset then idle; LFSR model MSB, POLY 16'h6801, SHIFTS=1. Expect: INIT cycle drives lfsr_load=1, lfsr_in=16'hACE1, then busy=0. Then req_valid=4'b0001 -> req_ready[0] pulses, one shift cycle, rsp_valid=1 with rsp_id=0, rsp_data=16'h31C3.
2. Reseed: seed_wr=1, seed_data=16'h0001, SHIFTS=1, then request from req 2. Expect seed_ack=1 in the first cycle, lfsr_load with lfsr_in=16'h0001 in the next, then rsp_id=2, rsp_data=16'h0002. Also with seed_data=0: expect lfsr_in=16'hACE1.
3. Round-robin with SHIFTS=16 and all req_valid=4'b1111 held, rsp_ready=1. Expect grant order 0,1,2,3,0, each response at 17 cycles after its req_ready, and lfsr_shift_en high exactly 16 cycles per grant.
4. Backpressure: rsp_ready=0 for 10 cycles in RESP. Expect rsp_valid, rsp_id and rsp_data stable, lfsr_shift_en=0, no new req_ready. Release -> IDLE next cycle.
5. Simultaneous events: seed_wr and req_valid[1] both rise while busy in SHIFT. Expect seed_ack first at the next IDLE, then LOAD, then req_ready[1].
6. Reset mid-SHIFT (cycle 5 of 16). Expect the next cycle to be INIT with lfsr_in=16'hACE1, rsp_valid never asserted, rr_ptr=0, and the pending requester re-granted after IDLE.
